// File: rtl/sa_result_drain_pkg.sv
// ---------------------------------------------------------------------------
// sa_result_drain_pkg
// Shared definitions for the systolic-array result drain:
//   PE_ROWS / PE_COLS  : array geometry (4x4)
//   ACC_W_DEF/OUT_W_DEF: default accumulator and stored-element widths
//   cap_state_t        : capture FSM state encoding
// ---------------------------------------------------------------------------
package sa_result_drain_pkg;

    localparam int PE_ROWS   = 4;
    localparam int PE_COLS   = 4;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    // IDLE means "next strobe is column 0"; ACTIVE covers columns 1..3.
    typedef enum logic {
        CAP_IDLE   = 1'b0,
        CAP_ACTIVE = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sa_result_drain_fifo.sv
// ---------------------------------------------------------------------------
// sa_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// o_data as soon as it is written, so a word pushed on edge N is readable
// right after edge N.
// Ports:
//   clk, rstn   clock / asynchronous active-low reset
//   i_push      write request (accepted when not full, or full with a pop)
//   i_data      write data
//   i_pop       read request (ignored when empty)
//   o_data      head entry, zero while empty
//   o_full      DEPTH entries held
//   o_empty     no entries held
//   o_level     current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sa_sync_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = i_pop & ~w_empty;
    // When full, a same-cycle pop frees the slot the write pointer already
    // points at (wr_ptr == rd_ptr), so the push can land there.
    assign w_push  = i_push & (~w_full | w_pop);

    // Storage has no reset; only pointers and level carry state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Asynchronous head read gives fall-through latency; gated to zero while
    // empty so the downstream bus is clean after reset.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/sa_result_drain.sv
// ---------------------------------------------------------------------------
// sa_result_drain
// Captures one 4-element result column per OutputSign strobe from the 4x4
// systolic array, formats each element to OUT_W bits, tags it with its
// result-RAM word address (tile*4 + col) and a last-column flag, and queues
// it for the result-RAM writer over valid/ready. The array cannot stall, so
// a column arriving at a full FIFO is dropped and flagged in overflow.
//
// Build option: define RESULT_SAT_EN to saturate each signed accumulator to
// the signed OUT_W range; otherwise elements are truncated to OUT_W LSBs.
//
// Ports:
//   clk, rstn            clock / asynchronous active-low reset
//   OutputSign           column-valid strobe
//   pe_out_0..pe_out_3   rows 0..3 of the current column
//   m_valid/m_ready      output handshake
//   m_data               {row3,row2,row1,row0}
//   m_addr               word address, modulo 2^ADDR_W
//   m_last               word is column 3 of its tile
//   tile_done            one-cycle pulse after an m_last word is accepted
//   overflow             sticky drop flag, cleared by clr_err (set wins)
//   fifo_level           FIFO occupancy
// ---------------------------------------------------------------------------
module sa_result_drain
    import sa_result_drain_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       OutputSign,
    input  logic [ACC_W-1:0]           pe_out_0,
    input  logic [ACC_W-1:0]           pe_out_1,
    input  logic [ACC_W-1:0]           pe_out_2,
    input  logic [ACC_W-1:0]           pe_out_3,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [4*OUT_W-1:0]         m_data,
    output logic [ADDR_W-1:0]          m_addr,
    output logic                       m_last,
    output logic                       tile_done,
    output logic                       overflow,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int COL_W   = $clog2(PE_COLS);
    localparam int TILE_W  = ADDR_W - COL_W;
    localparam int DATA_W  = PE_ROWS * OUT_W;
    localparam int ENTRY_W = DATA_W + ADDR_W + 1;

    // ------------------------------------------------------------------
    // Element formatting
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  w_pe [PE_ROWS];
    logic [DATA_W-1:0] w_col_fmt;

    assign w_pe[0] = pe_out_0;
    assign w_pe[1] = pe_out_1;
    assign w_pe[2] = pe_out_2;
    assign w_pe[3] = pe_out_3;

    generate
        for (genvar gi = 0; gi < PE_ROWS; gi++) begin : g_fmt
`ifdef RESULT_SAT_EN
            // Value fits when every bit from the OUT_W sign position upward
            // matches the accumulator sign; otherwise clamp to the rail.
            logic [ACC_W-OUT_W:0] w_hi;
            logic                 w_fits;
            assign w_hi   = w_pe[gi][ACC_W-1:OUT_W-1];
            assign w_fits = (&w_hi) | ~(|w_hi);
            assign w_col_fmt[gi*OUT_W +: OUT_W] =
                w_fits             ? w_pe[gi][OUT_W-1:0] :
                w_pe[gi][ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                     {1'b0, {(OUT_W-1){1'b1}}};
`else
            logic w_unused_hi;
            assign w_unused_hi = ^w_pe[gi][ACC_W-1:OUT_W];
            assign w_col_fmt[gi*OUT_W +: OUT_W] = w_pe[gi][OUT_W-1:0];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture FSM: column / tile counters. They advance on every strobe,
    // including dropped columns, so addresses stay aligned to the array.
    // ------------------------------------------------------------------
    cap_state_t        r_state;
    logic [COL_W-1:0]  r_col;
    logic [TILE_W-1:0] r_tile;
    logic              w_col_last;

    assign w_col_last = (r_state == CAP_ACTIVE) && (r_col == COL_W'(PE_COLS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= CAP_IDLE;
            r_col   <= '0;
            r_tile  <= '0;
        end else if (OutputSign) begin
            case (r_state)
                CAP_IDLE: begin
                    r_col   <= COL_W'(1);
                    r_state <= CAP_ACTIVE;
                end
                CAP_ACTIVE: begin
                    if (w_col_last) begin
                        r_col   <= '0;
                        r_tile  <= r_tile + TILE_W'(1);
                        r_state <= CAP_IDLE;
                    end else begin
                        r_col   <= r_col + COL_W'(1);
                    end
                end
                default: begin
                    r_col   <= '0;
                    r_state <= CAP_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;

    // Address is simply {tile, col}: tile*4 + col, wrapping at 2^ADDR_W.
    assign w_push_entry = {w_col_fmt, r_tile, r_col, w_col_last};

    assign w_pop  = m_valid & m_ready;
    assign w_drop = OutputSign & w_full & ~w_pop;

    sa_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (OutputSign),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign m_valid = ~w_empty;
    assign m_data  = w_head[ENTRY_W-1 -: DATA_W];
    assign m_addr  = w_head[ADDR_W:1];
    assign m_last  = w_head[0];

    // ------------------------------------------------------------------
    // Status: tile_done pulse and sticky overflow
    // ------------------------------------------------------------------
    logic r_tile_done;
    logic r_overflow;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tile_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_tile_done <= w_pop & m_last;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign tile_done = r_tile_done;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_sa_result_drain.sv
// ---------------------------------------------------------------------------
// tb_sa_result_drain
// Directed and randomized stimulus for sa_result_drain. A reference model
// keeps the expected queue of column words (address = strobe count since
// reset, last = every 4th strobe) and checks every output each cycle.
// Honours RESULT_SAT_EN for the expected element formatting.
// ---------------------------------------------------------------------------
module tb_sa_result_drain;

    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;

`ifdef RESULT_SAT_EN
    localparam logic [15:0] EXP_POS = 16'h7FFF;
`else
    localparam logic [15:0] EXP_POS = 16'h2345;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  addr;
        logic        last;
    } word_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              OutputSign = 1'b0;
    logic [ACC_W-1:0]  pe0 = '0, pe1 = '0, pe2 = '0, pe3 = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [63:0]       m_data;
    logic [7:0]        m_addr;
    logic              m_last;
    logic              tile_done;
    logic              overflow;
    logic              clr_err = 1'b0;
    logic [3:0]        fifo_level;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    strobes = 0;
    logic  ovf_m   = 1'b0;
    logic  td_m    = 1'b0;
    word_t exp_q[$];

    sa_result_drain #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .OutputSign (OutputSign),
        .pe_out_0   (pe0),
        .pe_out_1   (pe1),
        .pe_out_2   (pe2),
        .pe_out_3   (pe3),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_last     (m_last),
        .tile_done  (tile_done),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fmt_m(input logic [31:0] x);
`ifdef RESULT_SAT_EN
        longint v;
        v = longint'($signed(x));
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else                 return x[15:0];
`else
        return x[15:0];
`endif
    endfunction

    function automatic logic [31:0] rand_acc();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = 32'($urandom_range(0, 65535)) - 32'd32768;
            1:       r = $urandom;
            2:       r = 32'h0000_7FFF + 32'($urandom_range(0, 2));
            default: r = 32'hFFFF_8000 - 32'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_valid",    64'(m_valid),    64'(exp_q.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("overflow",   64'(overflow),   64'(ovf_m));
        chk("tile_done",  64'(tile_done),  64'(td_m));
        if (exp_q.size() != 0) begin
            chk("m_data", m_data,      exp_q[0].data);
            chk("m_addr", 64'(m_addr), 64'(exp_q[0].addr));
            chk("m_last", 64'(m_last), 64'(exp_q[0].last));
        end
    endtask

    // Apply the current inputs for one clock, advance the model, then check.
    task automatic tick();
        word_t w;
        bit    pop;
        bit    drop;
        pop  = (exp_q.size() != 0) && m_ready;
        drop = 1'b0;
        td_m = 1'b0;
        if (pop) begin
            w    = exp_q.pop_front();
            td_m = w.last;
        end
        if (OutputSign) begin
            w.data = {fmt_m(pe3), fmt_m(pe2), fmt_m(pe1), fmt_m(pe0)};
            w.addr = 8'(strobes % 256);
            w.last = (strobes % 4) == 3;
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else                      drop = 1'b1;
            strobes++;
        end
        if (drop)         ovf_m = 1'b1;
        else if (clr_err) ovf_m = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        $display("[TB] t=%0t os=%0b rdy=%0b valid=%0b addr=%0d last=%0b lvl=%0d ovf=%0b td=%0b",
                 $time, OutputSign, m_ready, m_valid, m_addr, m_last, fifo_level, overflow, tile_done);
    endtask

    task automatic do_reset();
        rstn = 1'b0; OutputSign = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
        #2;
        chk("rst_m_valid",   64'(m_valid),    64'd0);
        chk("rst_m_data",    m_data,          64'd0);
        chk("rst_m_addr",    64'(m_addr),     64'd0);
        chk("rst_m_last",    64'(m_last),     64'd0);
        chk("rst_tile_done", 64'(tile_done),  64'd0);
        chk("rst_overflow",  64'(overflow),   64'd0);
        chk("rst_level",     64'(fifo_level), 64'd0);
        exp_q.delete();
        strobes = 0; ovf_m = 1'b0; td_m = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_col(input int c);
        pe0 = 32'(10 * c + 0);
        pe1 = 32'(10 * c + 1);
        pe2 = 32'(10 * c + 2);
        pe3 = 32'(10 * c + 3);
    endtask

    initial begin
        // 1: one tile, ready high
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_col(c); OutputSign = 1'b1;
            tick();
            if (c == 0) chk("t1_col0_data", m_data, {16'd3, 16'd2, 16'd1, 16'd0});
        end
        OutputSign = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // 2: three tiles into a stalled FIFO, then drain
        do_reset();
        for (int s = 0; s < 12; s++) begin
            set_col(s); OutputSign = 1'b1;
            tick();
            if (s == 7) chk("t2_ovf_after8", 64'(overflow), 64'd0);
            if (s == 8) chk("t2_ovf_after9", 64'(overflow), 64'd1);
        end
        chk("t2_level_full", 64'(fifo_level), 64'd8);
        OutputSign = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t2_ovf_cleared", 64'(overflow), 64'd0);
        set_col(5); OutputSign = 1'b1;
        tick();
        chk("t2_next_tile_addr", 64'(m_addr), 64'd12);
        OutputSign = 1'b0; tick();

        // 3: gapped strobes within one tile
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_col(i); OutputSign = (i != 2 && i != 3);
            tick();
        end
        OutputSign = 1'b0;
        for (int i = 0; i < 2; i++) tick();

        // 4: reset mid-tile
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_col(i); OutputSign = 1'b1; tick();
        end
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_col(i); OutputSign = 1'b1;
            tick();
            chk("t4_addr", 64'(m_addr), 64'(i));
        end
        OutputSign = 1'b0; tick(); tick();

        // 5: formatting boundaries
        do_reset();
        m_ready = 1'b1;
        pe0 = 32'h0001_2345; pe1 = 32'hFFFE_0000; pe2 = 32'h0000_7FFF; pe3 = 32'h0000_0042;
        OutputSign = 1'b1;
        tick();
        chk("t5_fmt_pos", 64'(m_data[15:0]), 64'(EXP_POS));
        pe0 = 32'hFFFF_8000;
        tick();
        chk("t5_fmt_neg", 64'(m_data[15:0]), 64'h8000);
        OutputSign = 1'b0; tick(); tick();

        // 6: full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_col(i); OutputSign = 1'b1; tick();
        end
        m_ready = 1'b1; set_col(8);
        tick();
        chk("t6_level", 64'(fifo_level), 64'd8);
        chk("t6_ovf",   64'(overflow),   64'd0);
        m_ready = 1'b0; set_col(9);
        tick();
        chk("t6_ovf_drop", 64'(overflow), 64'd1);
        OutputSign = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            OutputSign = ($urandom_range(0, 9) < 7);
            m_ready    = ($urandom_range(0, 9) < 6);
            clr_err    = ($urandom_range(0, 19) == 0);
            pe0 = rand_acc(); pe1 = rand_acc(); pe2 = rand_acc(); pe3 = rand_acc();
            tick();
        end
        OutputSign = 1'b0; m_ready = 1'b1; clr_err = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
